// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//
// Contents:
//   state_e        loader FSM states
//   LEN_W          width of the word-count field in the frame header
//   BYTES_PER_WORD bytes assembled into one instruction word
//   is_busy_state  true for the states in which a load session is active

package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LEN0,
        WAIT_LEN1,
        DATA,
        WAIT_CHK,
        DONE,
        ERR
    } state_e;

    localparam int unsigned LEN_W          = 16;
    localparam int unsigned BYTES_PER_WORD = 4;

    // States in which the loader accepts stream bytes and reports busy.
    function automatic logic is_busy_state(state_e s);
        return (s == WAIT_LEN0) || (s == WAIT_LEN1) || (s == DATA) || (s == WAIT_CHK);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler for the boot loader.
//
// Collects BYTES_PER_WORD bytes, least-significant first. The first three
// bytes sit in a shift holding register; when the final byte arrives the
// complete word is presented combinationally together with word_valid.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   clear      in   restart assembly at byte lane 0 (new session)
//   byte_valid in   byte_data is accepted this cycle
//   byte_data  in   stream byte
//   word_valid out  byte_data completes a word this cycle
//   word       out  {byte_data, held bytes}, valid with word_valid

module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD);
    localparam int unsigned HOLD_W = 8 * (BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    assign word_valid = byte_valid && (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, hold_q};

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        hold_d     = hold_q;
        if (clear) begin
            byte_cnt_d = '0;
            hold_d     = '0;
        end else if (byte_valid) begin
            // Lane counter wraps to 0 after the last byte of a word.
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
            // Newest byte enters at the top so the oldest ends up lowest.
            hold_d     = {byte_data, hold_q[HOLD_W-1:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            hold_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
//
// Accepts a framed byte stream (LEN_LO, LEN_HI, 4*N payload bytes, CHK),
// writes each assembled little-endian word to the instruction RAM and keeps
// the core in reset until the whole program has loaded and the XOR checksum
// has matched.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   single-cycle request to begin a load session
//   rx_data    in   stream byte
//   rx_valid   in   rx_data is valid
//   rx_ready   out  loader can accept a byte (registered)
//   we         out  instruction-memory write enable, one-cycle pulse per word
//   waddr      out  word index written
//   wdata      out  instruction word {b3,b2,b1,b0}
//   busy       out  load session in progress
//   done       out  load complete and checksum matched (sticky)
//   error      out  length error or checksum mismatch (sticky)
//   core_rst_n out  active-low core reset, released only in DONE

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              core_rst_n
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
    logic [7:0]         chk_q, chk_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               rx_ready_q, rx_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               core_rst_n_q, core_rst_n_d;

    logic               accept;
    logic               start_ok;
    logic [LEN_W-1:0]   len_full;
    logic               len_too_big;
    logic               last_word;
    logic               asm_valid;
    logic               word_valid;
    logic [31:0]        word;

    assign accept   = rx_valid && rx_ready_q;
    // start is only honoured outside a session.
    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

    // Full length as it becomes known on the LEN_HI handshake.
    assign len_full    = {rx_data, len_q[7:0]};
    assign len_too_big = {1'b0, len_full} > (LEN_W + 1)'(MAX_WORDS);
    assign last_word   = (word_cnt_q == (len_q - LEN_W'(1)));

    assign asm_valid = accept && (state_q == DATA);

    imem_loader_word_assembler u_word_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .byte_valid (asm_valid),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        chk_d        = chk_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        done_d       = done_q;
        error_d      = error_q;
        core_rst_n_d = core_rst_n_q;

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start_ok) begin
                    state_d      = WAIT_LEN0;
                    len_d        = '0;
                    word_cnt_d   = '0;
                    chk_d        = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    core_rst_n_d = 1'b0;
                end
            end

            WAIT_LEN0: begin
                if (accept) begin
                    len_d   = LEN_W'(rx_data);
                    chk_d   = chk_q ^ rx_data;
                    state_d = WAIT_LEN1;
                end
            end

            WAIT_LEN1: begin
                if (accept) begin
                    len_d = len_full;
                    chk_d = chk_q ^ rx_data;
                    if (len_too_big) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else if (len_full == '0) begin
                        state_d = WAIT_CHK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    chk_d = chk_q ^ rx_data;
                    if (word_valid) begin
                        we_d       = 1'b1;
                        waddr_d    = word_cnt_q[ADDR_W-1:0];
                        wdata_d    = word;
                        word_cnt_d = word_cnt_q + LEN_W'(1);
                        // The CHK byte may arrive while the last write is on the port.
                        if (last_word) begin
                            state_d = WAIT_CHK;
                        end
                    end
                end
            end

            WAIT_CHK: begin
                if (accept) begin
                    if (rx_data == chk_q) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        core_rst_n_d = 1'b1;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake and busy flags are registered from the next state so that
        // rx_ready has no combinational path from rx_valid.
        rx_ready_d = is_busy_state(state_d);
        busy_d     = is_busy_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            chk_q        <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            rx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            chk_q        <= chk_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            rx_ready_q   <= rx_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        core_rst_n;

    int total = 0;
    int bad = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .core_rst_n (core_rst_n)
    );

    // Record every write seen on the memory port.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_addr.push_back(waddr);
            wr_data.push_back(wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Offer one byte and return #1 after the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (rx_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_byte_timeout: rx_ready=%b required 1", rx_ready);
            rx_valid = 1'b0;
        end else begin
            step();
            rx_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        total++;
        if ({rx_ready, we, waddr, wdata, busy, done, error, core_rst_n} !== '0) begin
            bad++;
            $display("FAIL reset_in: rdy=%b we=%b a=%h d=%h busy=%b done=%b err=%b crst=%b required all 0",
                     rx_ready, we, waddr, wdata, busy, done, error, core_rst_n);
        end
        rst_n = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h55;
        repeat (2) step();
        rx_valid = 1'b0;
        total++;
        if ({rx_ready, we, busy, done, error, core_rst_n} !== '0 || wr_addr.size() != 0) begin
            bad++;
            $display("FAIL reset_idle: rdy=%b we=%b busy=%b done=%b err=%b crst=%b writes=%0d required 0",
                     rx_ready, we, busy, done, error, core_rst_n, wr_addr.size());
        end
    endtask

    task automatic test_basic();
        logic [7:0] fr[10];
        fr = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'h70, 8'h00};
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        total++;
        if (busy !== 1'b1 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: busy=%b rdy=%b required 1 1", busy, rx_ready);
        end
        for (int i = 0; i < 10; i++) begin
            send_byte(fr[i]);
            if (i == 5) begin
                total++;
                if (we !== 1'b1 || waddr !== 8'h00 || wdata !== 32'h0050_0113) begin
                    bad++;
                    $display("FAIL basic_w0: we=%b a=%h d=%h required 1 00 00500113", we, waddr, wdata);
                end
            end
            if (i == 9) begin
                total++;
                if (we !== 1'b1 || waddr !== 8'h01 || wdata !== 32'h0070_0193) begin
                    bad++;
                    $display("FAIL basic_w1: we=%b a=%h d=%h required 1 01 00700193", we, waddr, wdata);
                end
            end
        end
        send_byte(8'hA2);
        total++;
        if (done !== 1'b1 || core_rst_n !== 1'b1 || error !== 1'b0 || busy !== 1'b0
            || rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done=%b crst=%b err=%b busy=%b rdy=%b required 1 1 0 0 0",
                     done, core_rst_n, error, busy, rx_ready);
        end
        // Bytes offered in DONE are not taken.
        rx_valid = 1'b1;
        rx_data = 8'hFF;
        repeat (3) step();
        rx_valid = 1'b0;
        total++;
        if (wr_addr.size() != 2 || rx_ready !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL basic_hold: writes=%0d rdy=%b done=%b required 2 0 1",
                     wr_addr.size(), rx_ready, done);
        end
    endtask

    task automatic test_bad_chk();
        logic [7:0] fr[11];
        fr = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'h70, 8'h00, 8'hA3};
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        total++;
        if (done !== 1'b0 || core_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL badchk_clear: done=%b crst=%b required 0 0", done, core_rst_n);
        end
        for (int i = 0; i < 11; i++) send_byte(fr[i]);
        total++;
        if (wr_addr.size() != 2 || error !== 1'b1 || done !== 1'b0 || core_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL badchk: writes=%0d err=%b done=%b crst=%b required 2 1 0 0",
                     wr_addr.size(), error, done, core_rst_n);
        end
    endtask

    task automatic test_len_edges();
        wr_addr.delete();
        pulse_start();
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL zero_clear: err=%b required 0", error);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        total++;
        if (done !== 1'b1 || error !== 1'b0 || wr_addr.size() != 0) begin
            bad++;
            $display("FAIL zero_len: done=%b err=%b writes=%0d required 1 0 0",
                     done, error, wr_addr.size());
        end
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        total++;
        if (error !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0 || busy !== 1'b0
            || wr_addr.size() != 0) begin
            bad++;
            $display("FAIL len_err: err=%b done=%b rdy=%b busy=%b writes=%0d required 1 0 0 0 0",
                     error, done, rx_ready, busy, wr_addr.size());
        end
    endtask

    task automatic test_stall_start();
        logic [7:0] fr[6];
        fr = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wr_addr.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            send_byte(fr[i]);
            if (i == 5) begin
                total++;
                if (we !== 1'b1 || waddr !== 8'h00 || wdata !== 32'hDEAD_BEEF) begin
                    bad++;
                    $display("FAIL stall_w: we=%b a=%h d=%h required 1 00 deadbeef", we, waddr, wdata);
                end
                step();
                total++;
                if (we !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_pulse: we=%b required 0", we);
                end
            end else if (i == 3) begin
                start = 1'b1;
                step();
                start = 1'b0;
                total++;
                if (busy !== 1'b1 || error !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_start: busy=%b err=%b required 1 0", busy, error);
                end
            end else begin
                step();
            end
        end
        send_byte(8'h23);
        total++;
        if (done !== 1'b1 || error !== 1'b0 || wr_addr.size() != 1) begin
            bad++;
            $display("FAIL stall_done: done=%b err=%b writes=%0d required 1 0 1",
                     done, error, wr_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] fr[7];
        fr = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45};
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        step();
        total++;
        if ({rx_ready, we, waddr, wdata, busy, done, error, core_rst_n} !== '0
            || wr_addr.size() != 0) begin
            bad++;
            $display("FAIL rst_mid: rdy=%b we=%b a=%h d=%h busy=%b done=%b err=%b crst=%b writes=%0d required all 0",
                     rx_ready, we, waddr, wdata, busy, done, error, core_rst_n, wr_addr.size());
        end
        rst_n = 1'b1;
        step();
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            send_byte(fr[i]);
            if (i == 5) begin
                total++;
                if (we !== 1'b1 || waddr !== 8'h00 || wdata !== 32'h1122_3344) begin
                    bad++;
                    $display("FAIL rst_reload_w: we=%b a=%h d=%h required 1 00 11223344",
                             we, waddr, wdata);
                end
            end
        end
        total++;
        if (done !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL rst_reload_done: done=%b err=%b required 1 0", done, error);
        end
    endtask

    task automatic test_full();
        logic [31:0] exp[256];
        logic [7:0]  chk;
        int          n;
        wr_addr.delete();
        wr_data.delete();
        chk = 8'h01;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        for (int i = 0; i < 256; i++) begin
            exp[i] = $urandom;
            for (int k = 0; k < 4; k++) begin
                send_byte(exp[i][8*k +: 8]);
                chk = chk ^ exp[i][8*k +: 8];
            end
        end
        send_byte(chk);
        step();
        total++;
        if (wr_addr.size() != 256 || done !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL full_done: writes=%0d done=%b err=%b required 256 1 0",
                     wr_addr.size(), done, error);
        end
        n = (wr_addr.size() < 256) ? wr_addr.size() : 256;
        for (int i = 0; i < n; i++) begin
            total++;
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== exp[i]) begin
                bad++;
                $display("FAIL full_word: idx=%0d a=%h d=%h required %h %h",
                         i, wr_addr[i], wr_data[i], 8'(i), exp[i]);
            end
        end
        if (n > 0) begin
            total++;
            if (wr_addr[n-1] !== 8'hFF) begin
                bad++;
                $display("FAIL full_last: a=%h required ff", wr_addr[n-1]);
            end
        end
        pulse_start();
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || core_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL reload_clear: done=%b busy=%b crst=%b required 0 1 0",
                     done, busy, core_rst_n);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reload_done: done=%b busy=%b required 1 0", done, busy);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_bad_chk();
        test_len_edges();
        test_stall_start();
        test_reset_mid();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
